// File: rtl/ps2_zx_keyboard.sv
// rtl/ps2_zx_keyboard.sv - PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix
//
// Purpose:
//   Receives PS/2 frames (start, 8 data LSB first, odd parity, stop), decodes
//   scan-code set 2 make/break sequences and holds a 40-bit pressed-key image
//   that is presented as eight active-low ZX matrix rows.
//
// Parameters:
//   CLK_FREQ   - system clock frequency in Hz
//   TIMEOUT_US - longest allowed gap between PS/2 falling edges inside a frame
//
// Ports:
//   clk                  in   system clock, rising edge
//   reset_n              in   asynchronous active-low reset
//   ps2_clk, ps2_data    in   raw asynchronous PS/2 lines
//   key_0 .. key_7 [4:0] out  matrix rows A8..A15, 0 = pressed
//   code [7:0]           out  last accepted scan byte
//   code_valid           out  one-cycle pulse per accepted byte
//   frame_err            out  one-cycle pulse per rejected frame
//
// Configuration:
//   PS2_ARROWS_EN - when defined, Backspace and the E0 arrow keys drive
//                   CS+digit composites from a separate composite register.

module ps2_zx_keyboard #(
   parameter int CLK_FREQ   = 27000000,
   parameter int TIMEOUT_US = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [4:0] key_0,
   output logic [4:0] key_1,
   output logic [4:0] key_2,
   output logic [4:0] key_3,
   output logic [4:0] key_4,
   output logic [4:0] key_5,
   output logic [4:0] key_6,
   output logic [4:0] key_7,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000000 * TIMEOUT_US;
   localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // Synchronisers reset to 1 (idle line level) so release never fakes an edge.
   logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
   logic ps2_data_meta_q, ps2_data_sync_q;
   logic fall_edge;

   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [TO_W-1:0] timeout_q, timeout_d;
   logic [7:0]      code_q, code_d;
   logic            code_valid_q, code_valid_d;
   logic            frame_err_q, frame_err_d;

   logic            brk_q, brk_d;
   logic            ext_q, ext_d;
   logic [39:0]     pressed_q, pressed_d;
   logic [39:0]     key_q, key_d;
   logic [6:0]      lookup;
   logic [39:0]     comp_vec;

`ifdef PS2_ARROWS_EN
   // Bits: 0 Backspace, 1 left, 2 down, 3 up, 4 right.
   logic [4:0]      composite_q, composite_d;
   logic [3:0]      comp_lookup;
`endif

   // Returns {valid, matrix index}; index = row*5 + bit.
   function automatic logic [6:0] map_key(input logic [7:0] sc);
      logic [6:0] r;
      r = 7'd0;
      case (sc)
         8'h12, 8'h59: r = {1'b1, 6'd0};
         8'h1A: r = {1'b1, 6'd1};
         8'h22: r = {1'b1, 6'd2};
         8'h21: r = {1'b1, 6'd3};
         8'h2A: r = {1'b1, 6'd4};
         8'h1C: r = {1'b1, 6'd5};
         8'h1B: r = {1'b1, 6'd6};
         8'h23: r = {1'b1, 6'd7};
         8'h2B: r = {1'b1, 6'd8};
         8'h34: r = {1'b1, 6'd9};
         8'h15: r = {1'b1, 6'd10};
         8'h1D: r = {1'b1, 6'd11};
         8'h24: r = {1'b1, 6'd12};
         8'h2D: r = {1'b1, 6'd13};
         8'h2C: r = {1'b1, 6'd14};
         8'h16: r = {1'b1, 6'd15};
         8'h1E: r = {1'b1, 6'd16};
         8'h26: r = {1'b1, 6'd17};
         8'h25: r = {1'b1, 6'd18};
         8'h2E: r = {1'b1, 6'd19};
         8'h45: r = {1'b1, 6'd20};
         8'h46: r = {1'b1, 6'd21};
         8'h3E: r = {1'b1, 6'd22};
         8'h3D: r = {1'b1, 6'd23};
         8'h36: r = {1'b1, 6'd24};
         8'h4D: r = {1'b1, 6'd25};
         8'h44: r = {1'b1, 6'd26};
         8'h43: r = {1'b1, 6'd27};
         8'h3C: r = {1'b1, 6'd28};
         8'h35: r = {1'b1, 6'd29};
         8'h5A: r = {1'b1, 6'd30};
         8'h4B: r = {1'b1, 6'd31};
         8'h42: r = {1'b1, 6'd32};
         8'h3B: r = {1'b1, 6'd33};
         8'h33: r = {1'b1, 6'd34};
         8'h29: r = {1'b1, 6'd35};
         8'h14: r = {1'b1, 6'd36};
         8'h3A: r = {1'b1, 6'd37};
         8'h31: r = {1'b1, 6'd38};
         8'h32: r = {1'b1, 6'd39};
         default: r = 7'd0;
      endcase
      return r;
   endfunction

`ifdef PS2_ARROWS_EN
   // Returns {valid, composite slot}.
   function automatic logic [3:0] map_comp(input logic ext, input logic [7:0] sc);
      logic [3:0] r;
      r = 4'd0;
      if (!ext) begin
         if (sc == 8'h66) r = {1'b1, 3'd0};
      end else begin
         case (sc)
            8'h6B:   r = {1'b1, 3'd1};
            8'h72:   r = {1'b1, 3'd2};
            8'h75:   r = {1'b1, 3'd3};
            8'h74:   r = {1'b1, 3'd4};
            default: r = 4'd0;
         endcase
      end
      return r;
   endfunction
`endif

   assign fall_edge = ps2_clk_prev_q & ~ps2_clk_sync_q;

   // Frame receiver
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      timeout_d    = timeout_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      if (state_q == S_IDLE || fall_edge) begin
         timeout_d = '0;
      end else if (timeout_q == TO_W'(TIMEOUT_CYCLES)) begin
         // Stalled frame: drop it silently.
         state_d   = S_IDLE;
         timeout_d = '0;
      end else begin
         timeout_d = timeout_q + TO_W'(1);
      end

      if (fall_edge) begin
         case (state_q)
            S_IDLE: begin
               if (!ps2_data_sync_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {ps2_data_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               parity_d = ps2_data_sync_q;
               state_d  = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (ps2_data_sync_q && (^{shift_q, parity_q})) begin
                  code_d       = shift_q;
                  code_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Scan-code decoder and matrix image
   always_comb begin
      brk_d     = brk_q;
      ext_d     = ext_q;
      pressed_d = pressed_q;
      lookup    = map_key(code_q);
`ifdef PS2_ARROWS_EN
      composite_d = composite_q;
      comp_lookup = map_comp(ext_q, code_q);
`endif
      if (code_valid_q) begin
         if (code_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (code_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!ext_q && lookup[6]) pressed_d[lookup[5:0]] = ~brk_q;
`ifdef PS2_ARROWS_EN
            if (comp_lookup[3]) composite_d[comp_lookup[2:0]] = ~brk_q;
`endif
         end
      end
   end

   always_comb begin
      comp_vec = '0;
`ifdef PS2_ARROWS_EN
      comp_vec[0]  = |composite_q;    // CS shared by every composite
      comp_vec[20] = composite_q[0];  // 0
      comp_vec[19] = composite_q[1];  // 5
      comp_vec[24] = composite_q[2];  // 6
      comp_vec[23] = composite_q[3];  // 7
      comp_vec[22] = composite_q[4];  // 8
`endif
      key_d = ~(pressed_q | comp_vec);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps2_clk_meta_q  <= 1'b1;
         ps2_clk_sync_q  <= 1'b1;
         ps2_clk_prev_q  <= 1'b1;
         ps2_data_meta_q <= 1'b1;
         ps2_data_sync_q <= 1'b1;
         state_q         <= S_IDLE;
         bit_cnt_q       <= 3'd0;
         shift_q         <= 8'd0;
         parity_q        <= 1'b0;
         timeout_q       <= '0;
         code_q          <= 8'd0;
         code_valid_q    <= 1'b0;
         frame_err_q     <= 1'b0;
         brk_q           <= 1'b0;
         ext_q           <= 1'b0;
         pressed_q       <= '0;
         key_q           <= '1;
`ifdef PS2_ARROWS_EN
         composite_q     <= '0;
`endif
      end else begin
         ps2_clk_meta_q  <= ps2_clk;
         ps2_clk_sync_q  <= ps2_clk_meta_q;
         ps2_clk_prev_q  <= ps2_clk_sync_q;
         ps2_data_meta_q <= ps2_data;
         ps2_data_sync_q <= ps2_data_meta_q;
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         parity_q        <= parity_d;
         timeout_q       <= timeout_d;
         code_q          <= code_d;
         code_valid_q    <= code_valid_d;
         frame_err_q     <= frame_err_d;
         brk_q           <= brk_d;
         ext_q           <= ext_d;
         pressed_q       <= pressed_d;
         key_q           <= key_d;
`ifdef PS2_ARROWS_EN
         composite_q     <= composite_d;
`endif
      end
   end

   assign key_0      = key_q[4:0];
   assign key_1      = key_q[9:5];
   assign key_2      = key_q[14:10];
   assign key_3      = key_q[19:15];
   assign key_4      = key_q[24:20];
   assign key_5      = key_q[29:25];
   assign key_6      = key_q[34:30];
   assign key_7      = key_q[39:35];
   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// tb/tb_ps2_zx_keyboard.sv - directed self-checking bench for ps2_zx_keyboard

module tb_ps2_zx_keyboard;

   localparam int HALF = 15;
   localparam logic [39:0] ALL_UP = '1;

   logic       clk = 1'b0;
   logic       reset_n, ps2_clk, ps2_data;
   logic [4:0] key_0, key_1, key_2, key_3, key_4, key_5, key_6, key_7;
   logic [7:0] code;
   logic       code_valid, frame_err;
   logic [39:0] rows;

   int checks = 0;
   int errors = 0;
   int cv_cnt = 0;
   int fe_cnt = 0;

   always #5 clk = ~clk;

   assign rows = {key_7, key_6, key_5, key_4, key_3, key_2, key_1, key_0};

   ps2_zx_keyboard #(.CLK_FREQ(1000000), .TIMEOUT_US(200)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_0(key_0), .key_1(key_1), .key_2(key_2), .key_3(key_3),
      .key_4(key_4), .key_5(key_5), .key_6(key_6), .key_7(key_7),
      .code(code), .code_valid(code_valid), .frame_err(frame_err)
   );

   always @(negedge clk) begin
      if (code_valid === 1'b1) cv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         wait_cycles(HALF);
         ps2_clk = 1'b0;
         wait_cycles(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_parity);
      logic [10:0] frame;
      frame = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
      send_bits(frame, 11);
      wait_cycles(20);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      wait_cycles(3);
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL reset_rows got %h want %h", rows, ALL_UP); end
      checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", code); end
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_code_valid got %b want 0", code_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      reset_n = 1'b1;
      wait_cycles(5);
   endtask

   task automatic test_basic;
      logic [10:0] frame;
      int c0, f0;
      bit found;
      c0 = cv_cnt; f0 = fe_cnt;
      frame = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
      send_bits(frame, 10);
      ps2_data = 1'b1;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (code_valid === 1'b1) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL basic_code_valid got none want pulse"); end
      if (found) begin
         @(posedge clk); @(posedge clk); #1;
         checks++; if (key_1 !== 5'b11110) begin errors++; $display("FAIL basic_key1_2cyc got %b want 11110", key_1); end
      end
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      wait_cycles(20);
      checks++; if (code !== 8'h1C) begin errors++; $display("FAIL basic_code got %h want 1c", code); end
      checks++; if (cv_cnt - c0 !== 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", cv_cnt - c0); end
      checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL basic_frame_err got %0d want 0", fe_cnt - f0); end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL basic_release got %h want %h", rows, ALL_UP); end
      checks++; if (cv_cnt - c0 !== 3) begin errors++; $display("FAIL basic_total_pulses got %0d want 3", cv_cnt - c0); end
   endtask

   task automatic test_parity_err;
      int c0, f0;
      c0 = cv_cnt; f0 = fe_cnt;
      send_byte(8'h1C, 1'b1);
      checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL parity_frame_err got %0d want 1", fe_cnt - f0); end
      checks++; if (cv_cnt - c0 !== 0) begin errors++; $display("FAIL parity_code_valid got %0d want 0", cv_cnt - c0); end
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL parity_rows got %h want %h", rows, ALL_UP); end
   endtask

   task automatic test_typematic;
      send_byte(8'h1C, 1'b0);
      send_byte(8'h1C, 1'b0);
      checks++; if (key_1 !== 5'b11110) begin errors++; $display("FAIL typematic_held got %b want 11110", key_1); end
      send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL typematic_release got %h want %h", rows, ALL_UP); end
      send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
      send_byte(8'h1A, 1'b0);
      checks++; if (key_0 !== 5'b11101) begin errors++; $display("FAIL stray_break_then_z got %b want 11101", key_0); end
      send_byte(8'hF0, 1'b0); send_byte(8'h1A, 1'b0);
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL z_release got %h want %h", rows, ALL_UP); end
   endtask

   task automatic test_composite;
      send_byte(8'h12, 1'b0);
      checks++; if (key_0 !== 5'b11110) begin errors++; $display("FAIL comp_shift got %b want 11110", key_0); end
      send_byte(8'h66, 1'b0);
      checks++; if (key_0 !== 5'b11110) begin errors++; $display("FAIL comp_bs_key0 got %b want 11110", key_0); end
`ifdef PS2_ARROWS_EN
      checks++; if (key_4 !== 5'b11110) begin errors++; $display("FAIL comp_bs_key4 got %b want 11110", key_4); end
`else
      checks++; if (key_4 !== 5'b11111) begin errors++; $display("FAIL comp_bs_key4 got %b want 11111", key_4); end
`endif
      send_byte(8'hF0, 1'b0); send_byte(8'h66, 1'b0);
      checks++; if (key_0 !== 5'b11110) begin errors++; $display("FAIL comp_release_key0 got %b want 11110", key_0); end
      checks++; if (key_4 !== 5'b11111) begin errors++; $display("FAIL comp_release_key4 got %b want 11111", key_4); end
      send_byte(8'hF0, 1'b0); send_byte(8'h12, 1'b0);
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL comp_all_up got %h want %h", rows, ALL_UP); end
   endtask

   task automatic test_timeout;
      int c0, f0;
      c0 = cv_cnt; f0 = fe_cnt;
      send_bits(11'b000_0001_0110, 5);
      wait_cycles(2000);
      checks++; if (cv_cnt - c0 !== 0) begin errors++; $display("FAIL timeout_code_valid got %0d want 0", cv_cnt - c0); end
      checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL timeout_frame_err got %0d want 0", fe_cnt - f0); end
      send_byte(8'h29, 1'b0);
      checks++; if (code !== 8'h29) begin errors++; $display("FAIL timeout_next_code got %h want 29", code); end
      checks++; if (key_7 !== 5'b11110) begin errors++; $display("FAIL timeout_space got %b want 11110", key_7); end
      send_byte(8'hF0, 1'b0); send_byte(8'h29, 1'b0);
   endtask

   task automatic test_reset_mid;
      int c0;
      send_byte(8'h15, 1'b0);
      checks++; if (key_2 !== 5'b11110) begin errors++; $display("FAIL mid_q_held got %b want 11110", key_2); end
      send_bits({1'b1, ~^8'h15, 8'h15, 1'b0}, 5);
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL mid_async_rows got %h want %h", rows, ALL_UP); end
      checks++; if (code !== 8'h00) begin errors++; $display("FAIL mid_async_code got %h want 00", code); end
      wait_cycles(4);
      reset_n = 1'b1;
      wait_cycles(5);
      c0 = cv_cnt;
      send_byte(8'h15, 1'b0);
      checks++; if (key_2 !== 5'b11110) begin errors++; $display("FAIL mid_after_release got %b want 11110", key_2); end
      checks++; if (cv_cnt - c0 !== 1) begin errors++; $display("FAIL mid_pulses got %0d want 1", cv_cnt - c0); end
      send_byte(8'hF0, 1'b0); send_byte(8'h15, 1'b0);
   endtask

   task automatic test_extended;
      send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
`ifdef PS2_ARROWS_EN
      checks++; if (key_0 !== 5'b11110) begin errors++; $display("FAIL ext_up_key0 got %b want 11110", key_0); end
      checks++; if (key_4 !== 5'b10111) begin errors++; $display("FAIL ext_up_key4 got %b want 10111", key_4); end
      send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
`endif
      checks++; if (rows !== ALL_UP) begin errors++; $display("FAIL ext_rows got %h want %h", rows, ALL_UP); end
      send_byte(8'h1C, 1'b0);
      checks++; if (key_1 !== 5'b11110) begin errors++; $display("FAIL ext_flag_cleared got %b want 11110", key_1); end
      send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_err();
      test_typematic();
      test_composite();
      test_timeout();
      test_reset_mid();
      test_extended();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
